// File: rtl/riscv_decode_stage.sv
// RISC-V decode pipeline stage: combinational format/immediate decode captured into a
// two-entry (main + skid) buffer so in_ready can be registered; flush and statistics counters.
module riscv_decode_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [2:0]       out_type,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stat_decoded,
  output logic [CNT_W-1:0] stat_illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_UNDEF = 3'd0;
  localparam logic [FMT_W-1:0] FMT_R     = 3'd1;
  localparam logic [FMT_W-1:0] FMT_I     = 3'd2;
  localparam logic [FMT_W-1:0] FMT_S     = 3'd3;
  localparam logic [FMT_W-1:0] FMT_B     = 3'd4;
  localparam logic [FMT_W-1:0] FMT_U     = 3'd5;
  localparam logic [FMT_W-1:0] FMT_J     = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [FMT_W-1:0] fmt;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  dec_t             main_q, main_d;
  dec_t             skid_q, skid_d;
  dec_t             dec_c;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_dec_q, cnt_dec_d;
  logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;
  logic             in_hs_c;
  logic             out_hs_c;

  // Format classification and immediate construction for the incoming word.
  always_comb begin
    dec_c        = '0;
    dec_c.pc     = in_pc;
    dec_c.opcode = in_insn[6:0];
    dec_c.rd     = in_insn[11:7];
    dec_c.funct3 = in_insn[14:12];
    dec_c.rs1    = in_insn[19:15];
    dec_c.rs2    = in_insn[24:20];
    dec_c.funct7 = in_insn[31:25];
    unique case (in_insn[6:0])
      7'b0110011: dec_c.fmt = FMT_R;
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011: begin
        dec_c.fmt = FMT_I;
        dec_c.imm = {{20{in_insn[31]}}, in_insn[31:20]};
      end
      7'b0100011: begin
        dec_c.fmt = FMT_S;
        dec_c.imm = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
      end
      7'b1100011: begin
        dec_c.fmt = FMT_B;
        dec_c.imm = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25],
                     in_insn[11:8], 1'b0};
      end
      7'b0110111,
      7'b0010111: begin
        dec_c.fmt = FMT_U;
        dec_c.imm = {in_insn[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_c.fmt = FMT_J;
        dec_c.imm = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20],
                     in_insn[30:21], 1'b0};
      end
      default: dec_c.fmt = FMT_UNDEF;
    endcase
    dec_c.illegal = (dec_c.fmt == FMT_UNDEF) || (in_insn[1:0] != 2'b11);
  end

  // Buffer FSM next state, entry loads and counter updates.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    cnt_dec_d = cnt_dec_q;
    cnt_ill_d = cnt_ill_q;
    in_hs_c   = in_valid & in_ready_q;
    out_hs_c  = out_valid_q & out_ready;

    if (out_hs_c) begin
      cnt_dec_d = cnt_dec_q + CNT_W'(1);
      if (main_q.illegal) begin
        cnt_ill_d = cnt_ill_q + CNT_W'(1);
      end
    end

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_hs_c) begin
            main_d  = dec_c;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_hs_c && out_hs_c) begin
            main_d = dec_c;
          end else if (out_hs_c) begin
            state_d = ST_EMPTY;
          end else if (in_hs_c) begin
            skid_d  = dec_c;
            state_d = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_hs_c) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_dec_q   <= '0;
      cnt_ill_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_SKID);
      cnt_dec_q   <= cnt_dec_d;
      cnt_ill_q   <= cnt_ill_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = main_q.pc;
  assign out_type     = main_q.fmt;
  assign out_opcode   = main_q.opcode;
  assign out_rd       = main_q.rd;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_funct3   = main_q.funct3;
  assign out_funct7   = main_q.funct7;
  assign out_imm      = main_q.imm;
  assign out_illegal  = main_q.illegal;
  assign stat_decoded = cnt_dec_q;
  assign stat_illegal = cnt_ill_q;

endmodule
